// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive paths.
package uart_pkg;

  // Serializer states; PARITY is only reachable when PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // FIFO pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    int unsigned aw;
    aw = $clog2(depth);
    return aw + 1;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serializer: pops bytes from the FIFO and shifts them out LSB first.
// Optional macro PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned D_W    = 8,
  parameter int unsigned B_TICK = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           b_clk,
  input  logic           valid,
  input  logic [D_W-1:0] head,
  output logic           pop_c,
  output logic           tx_data,
  output logic           b_en,
  output logic           tx_busy,
  output logic           tx_done
);

  localparam int unsigned TW = (B_TICK > 1) ? $clog2(B_TICK) : 1;
  localparam int unsigned BW = (D_W > 1) ? $clog2(D_W) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(B_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(D_W - 1);

  tx_state_t      state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [D_W-1:0] shift_q, shift_d;
  logic           done_d;
  logic           tx_d;
  logic           bit_end;
`ifdef PARITY_EN
  logic           par_q, par_d;
`endif

  // A bit period ends on the last oversampling tick.
  assign bit_end = b_clk && (tick_q == TICK_LAST);

  // Next-state, datapath and line-level decode.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
    done_d  = 1'b0;
    tx_d    = IDLE_LEVEL;
`ifdef PARITY_EN
    par_d   = par_q;
`endif

    if (b_clk && (state_q != IDLE)) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (valid) begin
          pop_c   = 1'b1;
          shift_d = head;
          tick_d  = '0;
          state_d = START;
`ifdef PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (valid) begin
            // Back-to-back frame: next start bit follows the stop bit directly.
            pop_c   = 1'b1;
            shift_d = head;
            state_d = START;
`ifdef PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx_data stays aligned with state_q.
    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_d[0];
`ifdef PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  // State, counters and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_data <= IDLE_LEVEL;
      b_en    <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_data <= tx_d;
      b_en    <= (state_d != IDLE);
      tx_busy <= (state_d != IDLE);
      tx_done <= done_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmit top: host-facing FIFO feeding the uart_tx serializer.
// Optional macro PARITY_EN adds an even-parity bit to every frame.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int unsigned D_W    = 8,
  parameter int unsigned B_TICK = 16,
  parameter int unsigned DEPTH  = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           b_clk,
  output logic           b_en,
  output logic           tx_data,
  input  logic           wr_en,
  input  logic [D_W-1:0] data_in,
  output logic           ff_full,
  output logic           ff_empty,
  output logic           ff_ovf,
  output logic           tx_busy,
  output logic           tx_done
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [D_W-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW-1:0]  wr_ptr_nxt, rd_ptr_nxt;
  logic           push;
  logic           pop_c;
  logic [D_W-1:0] head;

  // Writes while full are dropped; a pop never happens on an empty FIFO.
  assign push       = wr_en && !ff_full;
  assign wr_ptr_nxt = wr_ptr + PW'(push);
  assign rd_ptr_nxt = rd_ptr + PW'(pop_c);
  assign head       = mem[rd_ptr[AW-1:0]];

  // Storage array, no reset needed on the data itself.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  // Pointers and registered flags, computed from the post-update pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ff_empty <= 1'b1;
      ff_full  <= 1'b0;
      ff_ovf   <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      ff_empty <= (wr_ptr_nxt == rd_ptr_nxt);
      ff_full  <= (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                  (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      if (wr_en && ff_full) begin
        ff_ovf <= 1'b1;
      end
    end
  end

  uart_tx #(
    .D_W   (D_W),
    .B_TICK(B_TICK)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .b_clk  (b_clk),
    .valid  (!ff_empty),
    .head   (head),
    .pop_c  (pop_c),
    .tx_data(tx_data),
    .b_en   (b_en),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

endmodule
